laplacian_stream: RTL and testbench

Streaming, synthesizable 3x3 Laplacian edge filter for raster-order pixel streams. It replaces the file-based whole-frame filter with a line-buffered pipeline. It accepts one pixel per cycle over a valid/ready handshake and emits one filtered pixel per input pixel. It sits between the pixel source (image loader or camera front end) and downstream threshold/writer stages.

---
 rtl/laplacian_stream_pkg.sv | 19 +
 rtl/laplacian_stream_if.sv | 23 ++
 rtl/laplacian_stream_line_buffer.sv | 36 +++
 rtl/laplacian_stream.sv | 183 ++++++++++++++++++
 tb/tb_laplacian_stream.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/laplacian_stream_pkg.sv
// Shared types and constants for the streaming 3x3 Laplacian filter.
// Optional build macro LAPLACIAN_ABS_EN is consumed by laplacian_stream.
package laplacian_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam int MODE_POL_BIT  = 0;
    localparam int MODE_KERN_BIT = 1;

    // Eight neighbours minus 8x centre needs PIX_W+4 bits signed; one spare bit of headroom.
    function automatic int sum_width(input int pix_w);
        return pix_w + 5;
    endfunction

endpackage

// File: rtl/laplacian_stream_if.sv
// Pixel stream bundle: input handshake, output handshake, mode and frame marker.
interface laplacian_stream_if #(
    parameter int PIX_W = 8
);
    logic [1:0]       mode;
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_pix;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_pix;
    logic             frame_done;

    modport master (
        output mode, in_valid, in_pix, out_ready,
        input  in_ready, out_valid, out_pix, frame_done
    );

    modport slave (
        input  mode, in_valid, in_pix, out_ready,
        output in_ready, out_valid, out_pix, frame_done
    );
endinterface

// File: rtl/laplacian_stream_line_buffer.sv
// One-row delay line: dout presents the word written DEPTH writes ago (read-before-write).
module line_buffer #(
    parameter int DEPTH = 247,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    ptr_r;

    // Circular write pointer, advanced once per accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {AW{1'b0}};
        end else if (wr_en) begin
            ptr_r <= (ptr_r == LAST) ? {AW{1'b0}} : ptr_r + AW'(1);
        end
    end

    // Storage needs no reset: the FILL phase re-primes every location.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[ptr_r] <= din;
        end
    end

    assign dout = mem_r[ptr_r];

endmodule

// File: rtl/laplacian_stream.sv
// Streaming 3x3 Laplacian edge filter with two line buffers and a registered output stage.
// Define LAPLACIAN_ABS_EN to output the clamped magnitude instead of clamping negatives to 0.
module laplacian_stream
    import laplacian_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int COLS  = 247,
    parameter int ROWS  = 242
) (
    input  logic              clk,
    input  logic              rst_n,
    laplacian_stream_if.slave bus
);
    localparam int SUM_W = sum_width(PIX_W);
    localparam int TOTAL = ROWS * COLS;
    localparam int IW    = $clog2(TOTAL);
    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);

    localparam logic [IW-1:0] IDX_FILL_END = IW'(COLS);
    localparam logic [IW-1:0] IDX_LAST     = IW'(TOTAL - 1);
    localparam logic [CW-1:0] COL_LAST     = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST     = RW'(ROWS - 1);
    localparam logic signed [SUM_W-1:0] PIX_MAX = SUM_W'((1 << PIX_W) - 1);

    state_e                   state_r, state_nxt_s;
    logic                     ready_en_r;
    logic [1:0]               mode_r;
    logic [IW-1:0]            in_idx_r;
    logic [RW-1:0]            out_row_r;
    logic [CW-1:0]            out_col_r;
    logic                     out_valid_r, out_last_r;
    logic [PIX_W-1:0]         out_pix_r;
    // Left and centre window columns; the right column is the live line-buffer/input tap.
    logic [PIX_W-1:0]         win_r [3][2];
    logic [PIX_W-1:0]         lb0_s, lb1_s, filt_s;
    logic                     in_ready_s, accept_s, load_run_s, load_flush_s, load_s;
    logic                     border_s, is_last_s;
    logic signed [SUM_W-1:0]  n4_s, n8_s, ctr_s, raw_s, sum_s, mag_s;

    function automatic logic signed [SUM_W-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({{(SUM_W - PIX_W){1'b0}}, p});
    endfunction

    line_buffer #(.DEPTH(COLS), .WIDTH(PIX_W)) u_lb0 (
        .clk(clk), .rst_n(rst_n), .wr_en(accept_s), .din(bus.in_pix), .dout(lb0_s)
    );
    line_buffer #(.DEPTH(COLS), .WIDTH(PIX_W)) u_lb1 (
        .clk(clk), .rst_n(rst_n), .wr_en(accept_s), .din(lb0_s), .dout(lb1_s)
    );

    // Input acceptance depends on phase and on room in the output register.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_FILL:  in_ready_s = ready_en_r;
            ST_RUN:   in_ready_s = ready_en_r & (~out_valid_r | bus.out_ready);
            ST_FLUSH: in_ready_s = 1'b0;
            default:  in_ready_s = 1'b0;
        endcase
    end

    assign accept_s     = bus.in_valid & in_ready_s;
    assign load_run_s   = accept_s & (state_r == ST_RUN);
    assign load_flush_s = (state_r == ST_FLUSH) & (~out_valid_r | bus.out_ready) & ~out_last_r;
    assign load_s       = load_run_s | load_flush_s;
    assign border_s     = (out_row_r == {RW{1'b0}}) | (out_row_r == ROW_LAST) |
                          (out_col_r == {CW{1'b0}}) | (out_col_r == COL_LAST);
    assign is_last_s    = (out_row_r == ROW_LAST) & (out_col_r == COL_LAST);

    // Kernel sum over the window as it stands after shifting in the current pixel.
    always_comb begin
        n4_s  = ext(win_r[0][1]) + ext(win_r[2][1]) + ext(win_r[1][0]) + ext(lb0_s);
        n8_s  = n4_s + ext(win_r[0][0]) + ext(win_r[2][0]) + ext(lb1_s) + ext(bus.in_pix);
        ctr_s = ext(win_r[1][1]);
        if (mode_r[MODE_KERN_BIT]) begin
            raw_s = n8_s - (ctr_s <<< 2'd3);
        end else begin
            raw_s = n4_s - (ctr_s <<< 2'd2);
        end
        if (mode_r[MODE_POL_BIT]) begin
            sum_s = -raw_s;
        end else begin
            sum_s = raw_s;
        end
`ifdef LAPLACIAN_ABS_EN
        if (sum_s[SUM_W-1]) begin
            mag_s = -sum_s;
        end else begin
            mag_s = sum_s;
        end
`else
        mag_s = sum_s;
`endif
        if (mag_s[SUM_W-1]) begin
            filt_s = {PIX_W{1'b0}};
        end else if (mag_s > PIX_MAX) begin
            filt_s = {PIX_W{1'b1}};
        end else begin
            filt_s = mag_s[PIX_W-1:0];
        end
    end

    // Phase sequencing: prime window, stream, then drain the trailing border outputs.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_FILL: begin
                if (accept_s && (in_idx_r == IDX_FILL_END)) state_nxt_s = ST_RUN;
                else                                        state_nxt_s = ST_FILL;
            end
            ST_RUN: begin
                if (accept_s && (in_idx_r == IDX_LAST)) state_nxt_s = ST_FLUSH;
                else                                    state_nxt_s = ST_RUN;
            end
            ST_FLUSH: begin
                if (out_valid_r && out_last_r && bus.out_ready) state_nxt_s = ST_FILL;
                else                                            state_nxt_s = ST_FLUSH;
            end
            default: state_nxt_s = ST_FILL;
        endcase
    end

    // State register, input bookkeeping and window shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_FILL;
            ready_en_r <= 1'b0;
            mode_r     <= 2'b00;
            in_idx_r   <= {IW{1'b0}};
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 2; c++) begin
                    win_r[r][c] <= {PIX_W{1'b0}};
                end
            end
        end else begin
            state_r    <= state_nxt_s;
            ready_en_r <= 1'b1;
            if (accept_s && (state_r == ST_FILL) && (in_idx_r == {IW{1'b0}})) begin
                mode_r <= bus.mode;
            end
            if (accept_s) begin
                in_idx_r    <= (in_idx_r == IDX_LAST) ? {IW{1'b0}} : in_idx_r + IW'(1);
                win_r[0][0] <= win_r[0][1];
                win_r[1][0] <= win_r[1][1];
                win_r[2][0] <= win_r[2][1];
                win_r[0][1] <= lb1_s;
                win_r[1][1] <= lb0_s;
                win_r[2][1] <= bus.in_pix;
            end
        end
    end

    // Output register and centre-position counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_pix_r   <= {PIX_W{1'b0}};
            out_row_r   <= {RW{1'b0}};
            out_col_r   <= {CW{1'b0}};
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_last_r  <= is_last_s;
            out_pix_r   <= (load_run_s && !border_s) ? filt_s : {PIX_W{1'b0}};
            if (out_col_r == COL_LAST) begin
                out_col_r <= {CW{1'b0}};
                out_row_r <= (out_row_r == ROW_LAST) ? {RW{1'b0}} : out_row_r + RW'(1);
            end else begin
                out_col_r <= out_col_r + CW'(1);
            end
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_pix    = out_pix_r;
    assign bus.frame_done = out_valid_r & out_last_r & bus.out_ready;

endmodule

// File: tb/tb_laplacian_stream.sv
// Scoreboard bench: a 5x5 instance for directed frames and an 8x6 instance for random/stall/reset.
module tb_laplacian_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] drv_mode  [2];
    logic       drv_valid [2];
    logic [7:0] drv_pix   [2];
    logic       ordy      [2];
    bit         rnd_rdy   [2];
    logic       rdy [2], ov [2], fd [2];
    logic [7:0] opix [2];

    int n_tests = 0;
    int n_fail  = 0;
    int frame [$];
    int exp0 [$];
    int exp1 [$];
    int ocnt [2];
    bit held_v [2];
    int held_pix [2];

    laplacian_stream_if #(.PIX_W(8)) if5 ();
    laplacian_stream_if #(.PIX_W(8)) if8 ();

    laplacian_stream #(.PIX_W(8), .COLS(5), .ROWS(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(if5.slave));
    laplacian_stream #(.PIX_W(8), .COLS(8), .ROWS(6)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

    assign if5.mode = drv_mode[0];  assign if8.mode = drv_mode[1];
    assign if5.in_valid = drv_valid[0]; assign if8.in_valid = drv_valid[1];
    assign if5.in_pix = drv_pix[0]; assign if8.in_pix = drv_pix[1];
    assign if5.out_ready = ordy[0]; assign if8.out_ready = ordy[1];
    assign rdy[0] = if5.in_ready;   assign rdy[1] = if8.in_ready;
    assign ov[0] = if5.out_valid;   assign ov[1] = if8.out_valid;
    assign fd[0] = if5.frame_done;  assign fd[1] = if8.frame_done;
    assign opix[0] = if5.out_pix;   assign opix[1] = if8.out_pix;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int cols_of(input int d); return (d == 0) ? 5 : 8; endfunction
    function automatic int rows_of(input int d); return (d == 0) ? 5 : 6; endfunction
    function automatic int qsize(input int d); return (d == 0) ? exp0.size() : exp1.size(); endfunction

    // Reference Laplacian computed directly from frame coordinates.
    function automatic int golden(input int cols, input int rows, input int r, input int c,
                                  input logic [1:0] m);
        int s, all9, ctr, n4;
        if (r == 0 || r == rows - 1 || c == 0 || c == cols - 1) return 0;
        all9 = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                all9 += frame[(r + dr) * cols + c + dc];
        ctr = frame[r * cols + c];
        n4  = frame[(r - 1) * cols + c] + frame[(r + 1) * cols + c]
            + frame[r * cols + c - 1] + frame[r * cols + c + 1];
        s = m[1] ? (all9 - 9 * ctr) : (n4 - 4 * ctr);
        if (m[0]) s = -s;
`ifdef LAPLACIAN_ABS_EN
        if (s < 0) s = -s;
`endif
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    // Output ready generator: always ready, or a 50% random pattern.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) ordy[d] = rnd_rdy[d] ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pop/compare on each output handshake, and verify hold during stalls.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                held_v[d] = 1'b0;
            end else begin
                if (held_v[d]) begin
                    check_eq("hold_valid", int'(ov[d]), 1);
                    check_eq("hold_pix", int'(opix[d]), held_pix[d]);
                end
                if (ov[d] && ordy[d]) begin
                    if (qsize(d) == 0) begin
                        check_eq("unexpected_out", 1, 0);
                    end else begin
                        int e, tot;
                        e   = (d == 0) ? exp0.pop_front() : exp1.pop_front();
                        tot = cols_of(d) * rows_of(d);
                        check_eq($sformatf("pix%0d[%0d]", d, ocnt[d]), int'(opix[d]), e);
                        check_eq($sformatf("fdone%0d[%0d]", d, ocnt[d]), int'(fd[d]),
                                 (ocnt[d] == tot - 1) ? 1 : 0);
                        ocnt[d] = (ocnt[d] == tot - 1) ? 0 : ocnt[d] + 1;
                    end
                end
                held_v[d]   = ov[d] && !ordy[d];
                held_pix[d] = int'(opix[d]);
            end
        end
    end

    task automatic drive_frame(input int d, input int stop_after, input logic [1:0] m0,
                               input logic [1:0] m1, input bit gaps);
        int cols, rows, n;
        bit hs;
        cols = cols_of(d);
        rows = rows_of(d);
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++)
                if (d == 0) exp0.push_back(golden(cols, rows, r, c, m0));
                else        exp1.push_back(golden(cols, rows, r, c, m0));
        for (int i = 0; i < stop_after; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                drv_valid[d] = 1'b0;
                @(posedge clk); #1;
            end
            drv_valid[d] = 1'b1;
            drv_pix[d]   = 8'(frame[i]);
            drv_mode[d]  = (i == 0) ? m0 : m1;
            n = 0;
            do begin
                @(negedge clk);
                hs = rdy[d];
                @(posedge clk); #1;
                n++;
            end while (!hs && n < 200);
            if (!hs) begin
                check_eq("in_timeout", 0, 1);
                break;
            end
        end
        drv_valid[d] = 1'b0;
    endtask

    task automatic wait_drain(input int d);
        int n = 0;
        while (qsize(d) > 0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("drain_left", qsize(d), 0);
        @(negedge clk);
        check_eq("fill_ready", int'(rdy[d]), 1);
        @(posedge clk); #1;
    endtask

    task automatic make_impulse();
        frame.delete();
        for (int i = 0; i < 25; i++) frame.push_back((i == 12) ? 100 : 0);
    endtask

    task automatic make_random(input int n);
        frame.delete();
        for (int i = 0; i < n; i++) frame.push_back(int'($urandom_range(0, 255)));
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        exp0.delete();
        exp1.delete();
        ocnt[0] = 0;
        ocnt[1] = 0;
        @(negedge clk);
        check_eq("rst_in_ready", int'(rdy[1]), 0);
        check_eq("rst_out_valid", int'(ov[1]), 0);
        check_eq("rst_frame_done", int'(fd[1]), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_ready", int'(rdy[1]), 1);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            drv_valid[d] = 1'b0;
            drv_pix[d]   = 8'd0;
            drv_mode[d]  = 2'b00;
            rnd_rdy[d]   = 1'b0;
            ocnt[d]      = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_in_ready", int'(rdy[0]), 0);
        check_eq("reset_out_valid", int'(ov[0]), 0);
        check_eq("reset_out_pix", int'(opix[0]), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("fill_ready_after_reset", int'(rdy[0]), 1);

        // Flat frame yields all zeros.
        frame.delete();
        for (int i = 0; i < 25; i++) frame.push_back(77);
        drive_frame(0, 25, 2'b00, 2'b00, 1'b0);
        wait_drain(0);

        // Single bright pixel under every mode.
        for (int m = 0; m < 4; m++) begin
            make_impulse();
            drive_frame(0, 25, 2'(m), 2'(m), 1'b0);
            wait_drain(0);
        end

        // Random frames with stalls and input gaps.
        rnd_rdy[1] = 1'b1;
        make_random(48);
        drive_frame(1, 48, 2'b00, 2'b00, 1'b1);
        wait_drain(1);
        make_random(48);
        drive_frame(1, 48, 2'b11, 2'b11, 1'b1);
        wait_drain(1);

        // Abort a frame by reset, then a fresh frame whose mode changes after the first pixel.
        make_random(48);
        drive_frame(1, 13, 2'b01, 2'b01, 1'b0);
        pulse_reset();
        make_random(48);
        drive_frame(1, 48, 2'b10, 2'b01, 1'b1);
        wait_drain(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
